prefetch_fill: RTL and testbench

PREFETCH_FILL -- requirements
Module: prefetch_fill

---
 rtl/prefetch_fill.sv | 133 +++++++++++++
 tb/tb_prefetch_fill.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fill.sv
// Instruction prefetch queue: fetches 64-bit phrases over a simple req/ack bus
// and presents them as a stream of 16-bit words with their word addresses.
module prefetch_fill (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [22:0] flush_addr,
  output logic        bus_req,
  output logic [20:0] bus_addr,
  input  logic        bus_ack,
  input  logic [63:0] bus_data,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_data,
  output logic [22:0] ins_pc,
  output logic [3:0]  fill_count
);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [22:0] fetch_addr_q, fetch_addr_d;
  logic [22:0] ins_pc_q, ins_pc_d;
  logic [20:0] req_addr_q, req_addr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  fill_q, fill_d;
  logic [15:0] mem_q [8];
  logic [15:0] phrase_word [4];
  logic        wr_en;
  logic        consume;
  logic [2:0]  wr_n;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      phrase_word[k] = bus_data[63 - 16*k -: 16];
    end
  end

  // The bus address is latched separately so an outstanding request keeps its
  // address even when a flush reloads fetch_addr underneath it.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    req_addr_d   = req_addr_q;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush && fill_q <= 4'd4) begin
          state_d    = REQ;
          req_addr_d = fetch_addr_q[22:2];
        end
      end
      REQ: begin
        if (flush) begin
          state_d = bus_ack ? IDLE : DISCARD;
        end else if (bus_ack) begin
          wr_en        = 1'b1;
          fetch_addr_d = {fetch_addr_q[22:2] + 21'd1, 2'b00};
          state_d      = IDLE;
        end
      end
      DISCARD: begin
        if (bus_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      fetch_addr_d = flush_addr;
    end
  end

  assign wr_n    = 3'd4 - {1'b0, fetch_addr_q[1:0]};
  assign consume = ins_valid && ins_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    ins_pc_d = ins_pc_q;
    if (flush) begin
      rd_ptr_d = 3'd0;
      wr_ptr_d = 3'd0;
      fill_d   = 4'd0;
      ins_pc_d = flush_addr;
    end else begin
      rd_ptr_d = rd_ptr_q + {2'b00, consume};
      wr_ptr_d = wr_ptr_q + (wr_en ? wr_n : 3'd0);
      fill_d   = fill_q + (wr_en ? {1'b0, wr_n} : 4'd0) - {3'b000, consume};
      ins_pc_d = ins_pc_q + {22'd0, consume};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= 23'd0;
      ins_pc_q     <= 23'd0;
      req_addr_q   <= 21'd0;
      rd_ptr_q     <= 3'd0;
      wr_ptr_q     <= 3'd0;
      fill_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ins_pc_q     <= ins_pc_d;
      req_addr_q   <= req_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
    end
  end

  // Words from the starting offset up to the end of the phrase land in
  // consecutive queue slots.
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset && wr_en && (3'(i) < wr_n)) begin
        mem_q[wr_ptr_q + 3'(i)] <= phrase_word[fetch_addr_q[1:0] + 2'(i)];
      end
    end
  end

  assign bus_req    = (state_q != IDLE);
  assign bus_addr   = req_addr_q;
  assign ins_valid  = (fill_q != 4'd0);
  assign ins_data   = ins_valid ? mem_q[rd_ptr_q] : 16'h0000;
  assign ins_pc     = ins_pc_q;
  assign fill_count = fill_q;

endmodule

// File: tb/tb_prefetch_fill.sv
// Scoreboard bench for prefetch_fill: directed bus responses push expected
// words; a negedge monitor pops and compares every consumed word.
module tb_prefetch_fill;

  logic        sys_clk = 1'b0;
  logic        reset, flush, bus_ack, ins_ready;
  logic [22:0] flush_addr;
  logic [63:0] bus_data;
  logic        bus_req, ins_valid;
  logic [20:0] bus_addr;
  logic [15:0] ins_data;
  logic [22:0] ins_pc;
  logic [3:0]  fill_count;

  typedef struct packed {
    logic [22:0] pc;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   errors = 0;
  int   checks = 0;

  prefetch_fill dut (
    .sys_clk(sys_clk), .reset(reset), .flush(flush), .flush_addr(flush_addr),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_data(bus_data),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .fill_count(fill_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a consume happens at the next rising edge when valid and ready are high.
  always @(negedge sys_clk) begin
    if (!reset && !flush && ins_valid && ins_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got data 0x%0h pc 0x%0h, expected no word", ins_data, ins_pc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("ins_data", 32'(ins_data), 32'(monE.data));
        checkOutput("ins_pc", 32'(ins_pc), 32'(monE.pc));
      end
    end
  end

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic waitReq(input logic [20:0] expAddr);
    bit got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge sys_clk);
      if (bus_req) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: got no bus_req, expected request at 0x%0h", expAddr);
    end else begin
      checkOutput("bus_addr", 32'(bus_addr), 32'(expAddr));
    end
  endtask

  // Acknowledge the outstanding request and queue the words it should deliver.
  task automatic applyStimulus(input logic [63:0] data, input logic [22:0] startPc, input int offset);
    logic [22:0] pc = startPc;
    exp_t e;
    tick;
    bus_ack  = 1'b1;
    bus_data = data;
    for (int k = offset; k < 4; k++) begin
      e.pc   = pc;
      e.data = data[63 - 16*k -: 16];
      expQ.push_back(e);
      pc = pc + 23'd1;
    end
    tick;
    bus_ack = 1'b0;
  endtask

  task automatic drain;
    tick;
    ins_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge sys_clk);
      if (expQ.size() == 0 && fill_count == 4'd0) break;
    end
    checkOutput("drain_fill", 32'(fill_count), 32'd0);
  endtask

  task automatic flushAndDiscard(input logic [22:0] newAddr, input logic [20:0] oldAddr);
    waitReq(oldAddr);
    tick;
    flush      = 1'b1;
    flush_addr = newAddr;
    tick;
    flush = 1'b0;
    @(negedge sys_clk);
    checkOutput("discard_req", 32'(bus_req), 32'd1);
    checkOutput("discard_addr", 32'(bus_addr), 32'(oldAddr));
    checkOutput("flush_fill", 32'(fill_count), 32'd0);
    checkOutput("flush_pc", 32'(ins_pc), 32'(newAddr));
    tick;
    bus_ack  = 1'b1;
    bus_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick;
    bus_ack = 1'b0;
    @(negedge sys_clk);
    checkOutput("dropped_fill", 32'(fill_count), 32'd0);
  endtask

  task automatic pulseReady(input int n);
    tick;
    ins_ready = 1'b1;
    repeat (n) tick;
    ins_ready = 1'b0;
    @(negedge sys_clk);
  endtask

  initial begin
    reset      = 1'b1;
    flush      = 1'b0;
    flush_addr = '0;
    bus_ack    = 1'b0;
    bus_data   = '0;
    ins_ready  = 1'b0;
    repeat (3) tick;
    @(negedge sys_clk);
    checkOutput("rst_bus_req", 32'(bus_req), 32'd0);
    checkOutput("rst_fill", 32'(fill_count), 32'd0);
    checkOutput("rst_valid", 32'(ins_valid), 32'd0);
    checkOutput("rst_data", 32'(ins_data), 32'd0);
    checkOutput("rst_pc", 32'(ins_pc), 32'd0);

    // An ack seen in IDLE right after reset release must be ignored.
    tick;
    reset    = 1'b0;
    bus_ack  = 1'b1;
    bus_data = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    bus_ack = 1'b0;
    @(negedge sys_clk);
    checkOutput("idle_ack_fill", 32'(fill_count), 32'd0);
    checkOutput("first_req", 32'(bus_req), 32'd1);
    checkOutput("first_addr", 32'(bus_addr), 32'd0);

    // Reset with a request outstanding, ack coinciding with reset.
    tick;
    reset   = 1'b1;
    bus_ack = 1'b1;
    tick;
    bus_ack = 1'b0;
    @(negedge sys_clk);
    checkOutput("rst_abandon_req", 32'(bus_req), 32'd0);
    checkOutput("rst_abandon_fill", 32'(fill_count), 32'd0);
    tick;
    reset     = 1'b0;
    ins_ready = 1'b1;

    // Aligned fetch at 0x10.
    flushAndDiscard(23'h000010, 21'h0);
    waitReq(21'h000004);
    applyStimulus(64'h1111_2222_3333_4444, 23'h000010, 0);
    waitReq(21'h000005);
    drain;

    // Unaligned flush: only the last word of the phrase is kept.
    flushAndDiscard(23'h000013, 21'h000005);
    waitReq(21'h000004);
    applyStimulus(64'hAAAA_BBBB_CCCC_DDDD, 23'h000013, 3);
    drain;

    // Flush while a request is pending.
    flushAndDiscard(23'h000100, 21'h000005);
    waitReq(21'h000040);

    // Fill to 8 with the consumer stalled.
    tick;
    ins_ready = 1'b0;
    applyStimulus(64'h0100_0101_0102_0103, 23'h000100, 0);
    @(negedge sys_clk);
    checkOutput("fill_4", 32'(fill_count), 32'd4);
    waitReq(21'h000041);
    applyStimulus(64'h0104_0105_0106_0107, 23'h000104, 0);
    @(negedge sys_clk);
    checkOutput("fill_8", 32'(fill_count), 32'd8);
    repeat (3) @(negedge sys_clk);
    checkOutput("no_req_at_8", 32'(bus_req), 32'd0);
    pulseReady(1);
    checkOutput("fill_7", 32'(fill_count), 32'd7);
    repeat (2) @(negedge sys_clk);
    checkOutput("no_req_at_7", 32'(bus_req), 32'd0);
    pulseReady(2);
    checkOutput("fill_5", 32'(fill_count), 32'd5);
    checkOutput("no_req_at_5", 32'(bus_req), 32'd0);
    pulseReady(1);
    checkOutput("fill_4b", 32'(fill_count), 32'd4);
    waitReq(21'h000042);

    // Write of 4 and consume in the same cycle from fill 3.
    pulseReady(1);
    checkOutput("fill_3", 32'(fill_count), 32'd3);
    tick;
    ins_ready = 1'b1;
    bus_ack   = 1'b1;
    bus_data  = 64'h0108_0109_010A_010B;
    for (int k = 0; k < 4; k++) begin
      monE.pc   = 23'h000108 + 23'(k);
      monE.data = 16'h0108 + 16'(k);
      expQ.push_back(monE);
    end
    tick;
    ins_ready = 1'b0;
    bus_ack   = 1'b0;
    @(negedge sys_clk);
    checkOutput("fill_6", 32'(fill_count), 32'd6);
    drain;

    // Address wrap at the top of the address space.
    flushAndDiscard(23'h7FFFFC, 21'h000043);
    waitReq(21'h1FFFFF);
    applyStimulus(64'h0123_4567_89AB_CDEF, 23'h7FFFFC, 0);
    waitReq(21'h000000);
    applyStimulus(64'hFEDC_BA98_7654_3210, 23'h000000, 0);
    drain;

    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
